// File: rtl/stall_ctrl.sv
// Per-stage stall vector generator plus the multi-cycle EX hold FSM for the five-stage core.
// Optional consecutive-stall watchdog is compiled in with `define STALL_WDOG_EN.
module stall_ctrl #(
    parameter int unsigned MC_CNT_W   = 6,
    parameter int unsigned WDOG_LIMIT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_mem,
    input  logic                mc_start,
    input  logic [MC_CNT_W-1:0] mc_cycles,
    input  logic                mc_cancel,
    input  logic                flush,
    output logic [5:0]          stall,
    output logic                mc_busy,
    output logic                mc_done,
    output logic                stall_timeout
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [MC_CNT_W-1:0] r_cnt;
    logic [MC_CNT_W-1:0] w_cnt_d;
    logic                w_mc_hold;

    assign w_mc_hold = ((r_state == StIdle) && mc_start && (mc_cycles != '0)) ||
                       (r_state == StBusy);

    always_comb begin
        stall = 6'b000000;
        if (!rst) begin
            stall = 6'b000000;
        end else if (flush) begin
            stall = 6'b000000;
        end else if (stallreq_mem) begin
            stall = 6'b011111;
        end else if (w_mc_hold) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end else if (stallreq_if) begin
            stall = 6'b000011;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        if (flush || mc_cancel) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (mc_start && (mc_cycles > MC_CNT_W'(1))) begin
                        w_state_d = StBusy;
                        w_cnt_d   = mc_cycles - MC_CNT_W'(1);
                    end else if (mc_start && (mc_cycles == MC_CNT_W'(1))) begin
                        w_state_d = StDone;
                    end
                end
                StBusy: begin
                    // The unit keeps computing through MEM stalls, so no stall gating here.
                    w_cnt_d = r_cnt - MC_CNT_W'(1);
                    if (r_cnt == MC_CNT_W'(1)) begin
                        w_state_d = StDone;
                    end
                end
                StDone: begin
                    if (!stallreq_mem) begin
                        w_state_d = StIdle;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign mc_busy = (r_state != StIdle);
    assign mc_done = (r_state == StDone);

`ifdef STALL_WDOG_EN
    localparam logic [15:0] WdogLast = 16'(WDOG_LIMIT - 1);

    logic [15:0] r_wdog_cnt;
    logic        w_wdog_hit;

    // Pulse in the cycle that completes the run; the counter restarts from zero after it.
    assign w_wdog_hit    = (stall != 6'b000000) && (r_wdog_cnt == WdogLast);
    assign stall_timeout = w_wdog_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog_cnt <= '0;
        end else if ((stall == 6'b000000) || w_wdog_hit) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
        end
    end
`else
    logic w_unused_wdog;
    assign w_unused_wdog = ^WDOG_LIMIT;
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: directed stimulus pushes expectations, a negedge monitor checks.
module tb_stall_ctrl;

`ifdef STALL_WDOG_EN
    localparam bit WdogOn = 1'b1;
`else
    localparam bit WdogOn = 1'b0;
`endif
    localparam int WdogLimit = 4;

    logic       clk;
    logic       rst;
    logic       stallreq_if;
    logic       stallreq_id;
    logic       stallreq_mem;
    logic       mc_start;
    logic [5:0] mc_cycles;
    logic       mc_cancel;
    logic       flush;
    logic [5:0] stall;
    logic       mc_busy;
    logic       mc_done;
    logic       stall_timeout;

    typedef struct {
        string      nm;
        logic [5:0] stall;
        logic       busy;
        logic       done;
        logic       tmo;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   wd_run   = 0;

    stall_ctrl #(
        .MC_CNT_W  (6),
        .WDOG_LIMIT(WdogLimit)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .mc_cancel    (mc_cancel),
        .flush        (flush),
        .stall        (stall),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done),
        .stall_timeout(stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic chk(input string nm, input logic [5:0] s, input logic b, input logic d);
        exp_t e;
        e.nm    = nm;
        e.stall = s;
        e.busy  = b;
        e.done  = d;
        e.tmo   = 1'b0;
        if (WdogOn) begin
            wd_run = (s != 6'b000000) ? wd_run + 1 : 0;
            if (wd_run == WdogLimit) begin
                e.tmo  = 1'b1;
                wd_run = 0;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (stall !== e.stall) begin
                n_errors++;
                $display("FAIL %s stall: got %b want %b", e.nm, stall, e.stall);
            end
            n_checks++;
            if (mc_busy !== e.busy) begin
                n_errors++;
                $display("FAIL %s mc_busy: got %b want %b", e.nm, mc_busy, e.busy);
            end
            n_checks++;
            if (mc_done !== e.done) begin
                n_errors++;
                $display("FAIL %s mc_done: got %b want %b", e.nm, mc_done, e.done);
            end
            n_checks++;
            if (stall_timeout !== e.tmo) begin
                n_errors++;
                $display("FAIL %s stall_timeout: got %b want %b", e.nm, stall_timeout, e.tmo);
            end
        end
    end

    initial begin
        rst          = 1'b0;
        stallreq_if  = 1'b1;
        stallreq_id  = 1'b1;
        stallreq_mem = 1'b1;
        mc_start     = 1'b0;
        mc_cycles    = 6'd0;
        mc_cancel    = 1'b0;
        flush        = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with every request raised
        chk("rst_hold0", 6'b000000, 1'b0, 1'b0);
        chk("rst_hold1", 6'b000000, 1'b0, 1'b0);
        rst = 1'b1;
        chk("rst_release", 6'b011111, 1'b0, 1'b0);

        // Priority ladder
        chk("prio_all", 6'b011111, 1'b0, 1'b0);
        stallreq_mem = 1'b0;
        chk("prio_id", 6'b000111, 1'b0, 1'b0);
        stallreq_id = 1'b0;
        chk("prio_if", 6'b000011, 1'b0, 1'b0);
        flush = 1'b1;
        chk("prio_flush", 6'b000000, 1'b0, 1'b0);
        flush       = 1'b0;
        stallreq_if = 1'b0;
        chk("prio_none", 6'b000000, 1'b0, 1'b0);

        // k = 3 hold window
        mc_start  = 1'b1;
        mc_cycles = 6'd3;
        chk("k3_c0", 6'b001111, 1'b0, 1'b0);
        mc_start = 1'b0;
        chk("k3_c1", 6'b001111, 1'b1, 1'b0);
        chk("k3_c2", 6'b001111, 1'b1, 1'b0);
        chk("k3_done", 6'b000000, 1'b1, 1'b1);
        chk("k3_idle", 6'b000000, 1'b0, 1'b0);

        // k = 0 means no hold
        mc_start  = 1'b1;
        mc_cycles = 6'd0;
        chk("k0_c0", 6'b000000, 1'b0, 1'b0);
        mc_start = 1'b0;
        chk("k0_c1", 6'b000000, 1'b0, 1'b0);

        // k = 1, DONE held across MEM stall
        mc_start  = 1'b1;
        mc_cycles = 6'd1;
        chk("k1_c0", 6'b001111, 1'b0, 1'b0);
        mc_start     = 1'b0;
        stallreq_mem = 1'b1;
        chk("k1_memhold1", 6'b011111, 1'b1, 1'b1);
        chk("k1_memhold2", 6'b011111, 1'b1, 1'b1);
        chk("k1_memhold3", 6'b011111, 1'b1, 1'b1);
        stallreq_mem = 1'b0;
        chk("k1_release", 6'b000000, 1'b1, 1'b1);
        chk("k1_idle", 6'b000000, 1'b0, 1'b0);

        // Second start during BUSY is ignored
        mc_start  = 1'b1;
        mc_cycles = 6'd3;
        chk("ign_c0", 6'b001111, 1'b0, 1'b0);
        mc_cycles = 6'd7;
        chk("ign_c1", 6'b001111, 1'b1, 1'b0);
        mc_start = 1'b0;
        chk("ign_c2", 6'b001111, 1'b1, 1'b0);
        chk("ign_done", 6'b000000, 1'b1, 1'b1);
        chk("ign_idle", 6'b000000, 1'b0, 1'b0);

        // Cancel a k = 5 op at its second BUSY cycle
        mc_start  = 1'b1;
        mc_cycles = 6'd5;
        chk("cancel_c0", 6'b001111, 1'b0, 1'b0);
        mc_start = 1'b0;
        chk("cancel_busy1", 6'b001111, 1'b1, 1'b0);
        mc_cancel = 1'b1;
        chk("cancel_busy2", 6'b001111, 1'b1, 1'b0);
        mc_cancel = 1'b0;
        chk("cancel_idle0", 6'b000000, 1'b0, 1'b0);
        chk("cancel_idle1", 6'b000000, 1'b0, 1'b0);
        chk("cancel_idle2", 6'b000000, 1'b0, 1'b0);

        // Flush beats a same-cycle start
        flush     = 1'b1;
        mc_start  = 1'b1;
        mc_cycles = 6'd2;
        chk("flush_start", 6'b000000, 1'b0, 1'b0);
        flush    = 1'b0;
        mc_start = 1'b0;
        chk("flush_after", 6'b000000, 1'b0, 1'b0);

        // Hold overlays a load-use stall; FSM timing unchanged
        mc_start    = 1'b1;
        mc_cycles   = 6'd2;
        stallreq_id = 1'b1;
        chk("ovl_c0", 6'b001111, 1'b0, 1'b0);
        mc_start = 1'b0;
        chk("ovl_c1", 6'b001111, 1'b1, 1'b0);
        chk("ovl_done", 6'b000111, 1'b1, 1'b1);
        stallreq_id = 1'b0;
        chk("ovl_idle", 6'b000000, 1'b0, 1'b0);

        // Reset mid-operation abandons the op
        mc_start  = 1'b1;
        mc_cycles = 6'd4;
        chk("rstop_c0", 6'b001111, 1'b0, 1'b0);
        mc_start = 1'b0;
        chk("rstop_c1", 6'b001111, 1'b1, 1'b0);
        rst = 1'b0;
        chk("rstop_rst0", 6'b000000, 1'b1, 1'b0);
        chk("rstop_rst1", 6'b000000, 1'b0, 1'b0);
        rst = 1'b1;
        chk("rstop_after0", 6'b000000, 1'b0, 1'b0);
        chk("rstop_after1", 6'b000000, 1'b0, 1'b0);

        // Nine cycles of fetch stall for the watchdog
        stallreq_if = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("wdog_if%0d", i + 1), 6'b000011, 1'b0, 1'b0);
        end
        stallreq_if = 1'b0;
        chk("wdog_clear", 6'b000000, 1'b0, 1'b0);

        for (int i = 0; i < 4 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
